irq_ctrl: RTL and testbench

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_pkg.sv | 27 ++
 rtl/irq_ctrl_if.sv | 12 +
 rtl/irq_sync.sv | 40 ++++
 rtl/irq_ctrl.sv | 90 +++++++++
 tb/tb_irq_ctrl.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/irq_pkg.sv
// Shared constants, FSM encoding and the priority helper for the interrupt controller.
package irq_pkg;

  localparam int NUM_IRQ  = 4;
  localparam int IRQ_ID_W = $clog2(NUM_IRQ);

  localparam logic [1:0] ADDR_MASK    = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_CAUSE   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_DISPATCH   = 2'd1,
    ST_IN_SERVICE = 2'd2
  } state_e;

  // Lowest set index wins, so line 0 has the highest priority.
  function automatic logic [IRQ_ID_W-1:0] lowest_set(input logic [NUM_IRQ-1:0] v);
    logic [IRQ_ID_W-1:0] id;
    id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (v[i]) id = IRQ_ID_W'(i);
    end
    return id;
  endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// Register bus between the CPU side and the interrupt controller.
interface irq_ctrl_if;

  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output we, output addr, output wdata, input rdata);
  modport slave  (input we, input addr, input wdata, output rdata);

endinterface

// File: rtl/irq_sync.sv
// Per-line synchronizer chain plus history flop producing one-cycle rising-edge events.
module irq_sync
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int WIDTH       = NUM_IRQ
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] edge_o
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  hist_q;
  logic [WIDTH-1:0]                  armed_q;
  logic [SYNC_STAGES-1:0]            primed_q;
  logic [WIDTH-1:0]                  sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // A line only arms once the chain has refilled after reset and the line is
  // seen low, so a line held high through reset release never fires.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q   <= '0;
      hist_q   <= '0;
      armed_q  <= '0;
      primed_q <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], async_i};
      hist_q   <= sync_out;
      primed_q <= {primed_q[SYNC_STAGES-2:0], 1'b1};
      if (primed_q[SYNC_STAGES-1]) armed_q <= armed_q | ~sync_out;
    end
  end

  assign edge_o = sync_out & ~hist_q & armed_q;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: pending/mask registers, fixed-priority dispatch and a non-nesting service FSM.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_IRQ-1:0]  irq_in_i,
  input  logic                eret_i,
  irq_ctrl_if.slave           bus,
  output logic                int_req_o,
  output logic [IRQ_ID_W-1:0] int_id_o
);

  state_e                state_q, state_d;
  logic [NUM_IRQ-1:0]    mask_q, mask_d;
  logic [NUM_IRQ-1:0]    pend_q, pend_d;
  logic [IRQ_ID_W-1:0]   id_q, id_d;
  logic [NUM_IRQ-1:0]    edges;
  logic                  unused_wdata;

  assign unused_wdata = ^bus.wdata[31:NUM_IRQ];

  irq_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .WIDTH       (NUM_IRQ)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (irq_in_i),
    .edge_o  (edges)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      pend_q  <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      pend_q  <= pend_d;
      id_q    <= id_d;
    end
  end

  // Edge events are OR-ed in last so they beat both W1C and dispatch clears.
  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    pend_d    = pend_q;
    id_d      = id_q;
    int_req_o = 1'b0;
    if (bus.we && bus.addr == ADDR_MASK)    mask_d = bus.wdata[NUM_IRQ-1:0];
    if (bus.we && bus.addr == ADDR_PENDING) pend_d = pend_d & ~bus.wdata[NUM_IRQ-1:0];
    case (state_q)
      ST_IDLE: begin
        if (|(pend_q & mask_q)) begin
          state_d = ST_DISPATCH;
          id_d    = lowest_set(pend_q & mask_q);
        end
      end
      ST_DISPATCH: begin
        int_req_o    = 1'b1;
        pend_d[id_q] = 1'b0;
        state_d      = ST_IN_SERVICE;
      end
      ST_IN_SERVICE: begin
        if (eret_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    pend_d = pend_d | edges;
  end

  always_comb begin
    bus.rdata = '0;
    case (bus.addr)
      ADDR_MASK:    bus.rdata = {{(32-NUM_IRQ){1'b0}}, mask_q};
      ADDR_PENDING: bus.rdata = {{(32-NUM_IRQ){1'b0}}, pend_q};
      ADDR_CAUSE:   bus.rdata = {{(31-IRQ_ID_W){1'b0}}, (state_q == ST_IN_SERVICE), id_q};
      default:      bus.rdata = '0;
    endcase
  end

  assign int_id_o = id_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl; inputs change and outputs are sampled 1 ns after each rising edge.
module tb_irq_ctrl;
  import irq_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq;
  logic       eret;
  logic       int_req;
  logic [1:0] int_id;
  int         checks = 0;
  int         errors = 0;
  int         pulses = 0;

  irq_ctrl_if bus ();

  irq_ctrl #(.SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .irq_in_i  (irq),
    .eret_i    (eret),
    .bus       (bus),
    .int_req_o (int_req),
    .int_id_o  (int_id)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (int_req === 1'b1) pulses++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
    bus.we    = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    tick();
    bus.we    = 1'b0;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
    bus.addr = a;
    #1;
    d = bus.rdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    tick(); tick();
    checks++; if (int_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_int_req: got %b expected 0", int_req); end
    checks++; if (int_id !== 2'd0) begin errors++; $display("[TB] FAIL reset_int_id: got %0d expected 0", int_id); end
    read_reg(ADDR_MASK, d);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL reset_mask: got %0h expected 0", d); end
    read_reg(ADDR_PENDING, d);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL reset_pending: got %0h expected 0", d); end
    read_reg(ADDR_CAUSE, d);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL reset_cause: got %0h expected 0", d); end
    reset = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reg_access();
    logic [31:0] d;
    write_reg(ADDR_MASK, 32'hFFFF_FFF5);
    read_reg(ADDR_MASK, d);
    checks++; if (d !== 32'h5) begin errors++; $display("[TB] FAIL mask_rw: got %0h expected 5", d); end
    write_reg(ADDR_CAUSE, 32'hF);
    write_reg(2'd3, 32'hF);
    read_reg(ADDR_MASK, d);
    checks++; if (d !== 32'h5) begin errors++; $display("[TB] FAIL mask_after_rsvd_write: got %0h expected 5", d); end
    read_reg(ADDR_CAUSE, d);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL cause_after_write: got %0h expected 0", d); end
    read_reg(2'd3, d);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL rsvd_read: got %0h expected 0", d); end
    write_reg(ADDR_MASK, 32'h0);
  endtask

  task automatic test_single();
    logic [31:0] d;
    int p0;
    write_reg(ADDR_MASK, 32'hF);
    p0  = pulses;
    irq = 4'b0100;
    tick(); tick();
    read_reg(ADDR_PENDING, d);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL single_pend_early: got %0h expected 0", d); end
    tick();
    read_reg(ADDR_PENDING, d);
    checks++; if (d !== 32'h4) begin errors++; $display("[TB] FAIL single_pend_set: got %0h expected 4", d); end
    checks++; if (int_req !== 1'b0) begin errors++; $display("[TB] FAIL single_req_early: got %b expected 0", int_req); end
    tick();
    checks++; if (int_req !== 1'b1) begin errors++; $display("[TB] FAIL single_req: got %b expected 1", int_req); end
    checks++; if (int_id !== 2'd2) begin errors++; $display("[TB] FAIL single_id: got %0d expected 2", int_id); end
    tick();
    checks++; if (int_req !== 1'b0) begin errors++; $display("[TB] FAIL single_req_end: got %b expected 0", int_req); end
    read_reg(ADDR_PENDING, d);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL single_pend_clr: got %0h expected 0", d); end
    read_reg(ADDR_CAUSE, d);
    checks++; if (d !== 32'h6) begin errors++; $display("[TB] FAIL single_cause: got %0h expected 6", d); end
    checks++; if (pulses - p0 !== 1) begin errors++; $display("[TB] FAIL single_pulses: got %0d expected 1", pulses - p0); end
    eret = 1'b1; tick(); eret = 1'b0;
    read_reg(ADDR_CAUSE, d);
    checks++; if (d !== 32'h2) begin errors++; $display("[TB] FAIL single_cause_idle: got %0h expected 2", d); end
    irq = 4'b0000;
    repeat (4) tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    int p0;
    p0  = pulses;
    irq = 4'b1010;
    tick(); tick(); tick();
    read_reg(ADDR_PENDING, d);
    checks++; if (d !== 32'hA) begin errors++; $display("[TB] FAIL b2b_pend: got %0h expected a", d); end
    tick();
    checks++; if (int_req !== 1'b1 || int_id !== 2'd1) begin errors++; $display("[TB] FAIL b2b_first: got req=%b id=%0d expected req=1 id=1", int_req, int_id); end
    tick(); tick(); tick();
    read_reg(ADDR_PENDING, d);
    checks++; if (d !== 32'h8) begin errors++; $display("[TB] FAIL b2b_pend_left: got %0h expected 8", d); end
    checks++; if (pulses - p0 !== 1) begin errors++; $display("[TB] FAIL b2b_no_nest: got %0d pulses expected 1", pulses - p0); end
    eret = 1'b1; tick(); eret = 1'b0;
    read_reg(ADDR_CAUSE, d);
    checks++; if (d !== 32'h1 || int_req !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle: got cause=%0h req=%b expected cause=1 req=0", d, int_req); end
    tick();
    checks++; if (int_req !== 1'b1 || int_id !== 2'd3) begin errors++; $display("[TB] FAIL b2b_second: got req=%b id=%0d expected req=1 id=3", int_req, int_id); end
    tick();
    read_reg(ADDR_CAUSE, d);
    checks++; if (d !== 32'h7) begin errors++; $display("[TB] FAIL b2b_cause: got %0h expected 7", d); end
    checks++; if (pulses - p0 !== 2) begin errors++; $display("[TB] FAIL b2b_pulses: got %0d expected 2", pulses - p0); end
    eret = 1'b1; tick(); eret = 1'b0;
    irq = 4'b0000;
    repeat (4) tick();
  endtask

  task automatic test_masked();
    logic [31:0] d;
    int p0;
    write_reg(ADDR_MASK, 32'h0);
    p0  = pulses;
    irq = 4'b0001;
    tick();
    irq = 4'b0000;
    repeat (5) tick();
    read_reg(ADDR_PENDING, d);
    checks++; if (d !== 32'h1) begin errors++; $display("[TB] FAIL masked_pend: got %0h expected 1", d); end
    checks++; if (pulses !== p0) begin errors++; $display("[TB] FAIL masked_no_req: got %0d pulses expected 0", pulses - p0); end
    write_reg(ADDR_MASK, 32'h1);
    tick();
    checks++; if (int_req !== 1'b1 || int_id !== 2'd0) begin errors++; $display("[TB] FAIL unmask_req: got req=%b id=%0d expected req=1 id=0", int_req, int_id); end
    tick();
    read_reg(ADDR_CAUSE, d);
    checks++; if (d !== 32'h4) begin errors++; $display("[TB] FAIL unmask_cause: got %0h expected 4", d); end
    eret = 1'b1; tick(); eret = 1'b0;
    tick();
  endtask

  task automatic test_in_service();
    logic [31:0] d;
    int p0;
    write_reg(ADDR_MASK, 32'hF);
    p0  = pulses;
    irq = 4'b0100;
    repeat (4) tick();
    checks++; if (int_req !== 1'b1 || int_id !== 2'd2) begin errors++; $display("[TB] FAIL svc_first: got req=%b id=%0d expected req=1 id=2", int_req, int_id); end
    tick();
    irq = 4'b0101;
    repeat (5) tick();
    read_reg(ADDR_PENDING, d);
    checks++; if (d !== 32'h1) begin errors++; $display("[TB] FAIL svc_pend_accum: got %0h expected 1", d); end
    read_reg(ADDR_CAUSE, d);
    checks++; if (d !== 32'h6) begin errors++; $display("[TB] FAIL svc_cause: got %0h expected 6", d); end
    checks++; if (pulses - p0 !== 1) begin errors++; $display("[TB] FAIL svc_no_nest: got %0d pulses expected 1", pulses - p0); end
    eret = 1'b1; tick(); eret = 1'b0;
    checks++; if (int_req !== 1'b0) begin errors++; $display("[TB] FAIL svc_eret_idle: got %b expected 0", int_req); end
    tick();
    checks++; if (int_req !== 1'b1 || int_id !== 2'd0) begin errors++; $display("[TB] FAIL svc_second: got req=%b id=%0d expected req=1 id=0", int_req, int_id); end
    tick();
    eret = 1'b1; tick(); eret = 1'b0;
    p0 = pulses;
    eret = 1'b1; tick(); eret = 1'b0;
    tick();
    read_reg(ADDR_CAUSE, d);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL eret_idle_cause: got %0h expected 0", d); end
    checks++; if (pulses !== p0) begin errors++; $display("[TB] FAIL eret_idle_req: got %0d pulses expected 0", pulses - p0); end
    irq = 4'b0000;
    repeat (4) tick();
  endtask

  task automatic test_w1c_collision();
    logic [31:0] d;
    write_reg(ADDR_MASK, 32'h0);
    irq = 4'b0010;
    tick(); tick();
    bus.we    = 1'b1;
    bus.addr  = ADDR_PENDING;
    bus.wdata = 32'h2;
    tick();
    bus.we    = 1'b0;
    read_reg(ADDR_PENDING, d);
    checks++; if (d !== 32'h2) begin errors++; $display("[TB] FAIL w1c_set_wins: got %0h expected 2", d); end
    write_reg(ADDR_PENDING, 32'h2);
    read_reg(ADDR_PENDING, d);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL w1c_clear: got %0h expected 0", d); end
    irq = 4'b0000;
    repeat (4) tick();
  endtask

  task automatic test_reset_in_service();
    logic [31:0] d;
    int p0;
    write_reg(ADDR_MASK, 32'hF);
    irq = 4'b0100;
    repeat (5) tick();
    read_reg(ADDR_CAUSE, d);
    checks++; if (d !== 32'h6) begin errors++; $display("[TB] FAIL rst_svc_cause: got %0h expected 6", d); end
    reset = 1'b1;
    #1;
    checks++; if (int_req !== 1'b0 || int_id !== 2'd0) begin errors++; $display("[TB] FAIL rst_outputs: got req=%b id=%0d expected 0 0", int_req, int_id); end
    read_reg(ADDR_CAUSE, d);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL rst_cause: got %0h expected 0", d); end
    tick(); tick();
    reset = 1'b0;
    write_reg(ADDR_MASK, 32'hF);
    p0 = pulses;
    repeat (8) tick();
    read_reg(ADDR_PENDING, d);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL rst_held_pend: got %0h expected 0", d); end
    checks++; if (pulses !== p0) begin errors++; $display("[TB] FAIL rst_held_req: got %0d pulses expected 0", pulses - p0); end
    irq = 4'b0000;
    repeat (4) tick();
    irq = 4'b0100;
    tick(); tick(); tick();
    read_reg(ADDR_PENDING, d);
    checks++; if (d !== 32'h4) begin errors++; $display("[TB] FAIL rst_rearm_pend: got %0h expected 4", d); end
    tick();
    checks++; if (int_req !== 1'b1 || int_id !== 2'd2) begin errors++; $display("[TB] FAIL rst_rearm_req: got req=%b id=%0d expected req=1 id=2", int_req, int_id); end
    tick();
    eret = 1'b1; tick(); eret = 1'b0;
    irq = 4'b0000;
    repeat (2) tick();
  endtask

  initial begin
    reset     = 1'b1;
    irq       = 4'b0000;
    eret      = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = 2'd0;
    bus.wdata = 32'h0;
    test_reset();
    test_reg_access();
    test_single();
    test_back_to_back();
    test_masked();
    test_in_service();
    test_w1c_collision();
    test_reset_in_service();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
